demux_serial_1_para_2: RTL

Serial-to-parallel 1-to-2 demultiplexer for the ALU datapath. It receives framed words on a single serial line, one bit per clock. Each frame carries a channel selector bit followed by a LARGURA-bit data word. The block deserializes the word and delivers it to output channel 0 or channel 1 according to the selector, so it is the receiving end of the serialized 2-to-1 selection path. Each channel holds its last word and raises a one-cycle valid pulse on update.

---
 rtl/demux_serial_1_para_2_if.sv | 23 ++
 rtl/demux_serial_1_para_2.sv | 105 ++++++++++
 2 files changed

// File: rtl/demux_serial_1_para_2_if.sv
// Bundle of the serial line and the two-channel parallel side of the 1-to-2 demux.
// The master drives the serial line and the slave, which is the demux, drives the channel outputs.
interface demux_serial_1_para_2_if #(
   parameter int LARGURA = 4
);
   logic               D;
   logic [LARGURA-1:0] Y0;
   logic [LARGURA-1:0] Y1;
   logic               valido0;
   logic               valido1;
   logic               erro_quadro;
   logic               ocupado;

   modport master (
      output D,
      input  Y0, Y1, valido0, valido1, erro_quadro, ocupado
   );

   modport slave (
      input  D,
      output Y0, Y1, valido0, valido1, erro_quadro, ocupado
   );
endinterface

// File: rtl/demux_serial_1_para_2.sv
// Serial-to-parallel 1-to-2 demux. Each frame is start(0), selector, LARGURA data bits
// sent LSB first, and stop(1). The received word is steered to channel 0 or channel 1.
module demux_serial_1_para_2 #(
   parameter int LARGURA = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   demux_serial_1_para_2_if.slave bus
);

   localparam int CW = $clog2(LARGURA + 1);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      SELETOR = 2'd1,
      DADOS   = 2'd2,
      PARADA  = 2'd3
   } estado_t;

   estado_t            estado, estado_nxt;
   logic [LARGURA-1:0] shift_r, shift_nxt;
   logic [LARGURA-1:0] y0_r, y1_r;
   logic [CW-1:0]      cnt_r;
   logic               sel_r;
   logic               v0_r, v1_r, erro_r;
   logic               carrega_sel, desloca, entrega, falha;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) estado <= OCIOSO;
      else        estado <= estado_nxt;
   end

   always_comb begin
      estado_nxt  = estado;
      carrega_sel = 1'b0;
      desloca     = 1'b0;
      entrega     = 1'b0;
      falha       = 1'b0;
      case (estado)
         OCIOSO:  if (!bus.D) estado_nxt = SELETOR;
         SELETOR: begin
            carrega_sel = 1'b1;
            estado_nxt  = DADOS;
         end
         DADOS: begin
            desloca = 1'b1;
            if (cnt_r == CW'(LARGURA - 1)) estado_nxt = PARADA;
         end
         PARADA: begin
            estado_nxt = OCIOSO;
            if (bus.D) entrega = 1'b1;
            else       falha   = 1'b1;
         end
         default: estado_nxt = OCIOSO;
      endcase
   end

   // LSB arrives first, so each new bit enters at the top and moves down one place per clock.
   always_comb begin
      shift_nxt              = shift_r >> 1;
      shift_nxt[LARGURA-1]   = bus.D;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r <= '0;
         cnt_r   <= '0;
         sel_r   <= 1'b0;
         y0_r    <= '0;
         y1_r    <= '0;
         v0_r    <= 1'b0;
         v1_r    <= 1'b0;
         erro_r  <= 1'b0;
      end else begin
         v0_r   <= 1'b0;
         v1_r   <= 1'b0;
         erro_r <= falha;
         if (carrega_sel) begin
            sel_r <= bus.D;
            cnt_r <= '0;
         end
         if (desloca) begin
            shift_r <= shift_nxt;
            cnt_r   <= cnt_r + CW'(1);
         end
         if (entrega) begin
            if (sel_r) begin
               y1_r <= shift_r;
               v1_r <= 1'b1;
            end else begin
               y0_r <= shift_r;
               v0_r <= 1'b1;
            end
         end
      end
   end

   assign bus.Y0          = y0_r;
   assign bus.Y1          = y1_r;
   assign bus.valido0     = v0_r;
   assign bus.valido1     = v1_r;
   assign bus.erro_quadro = erro_r;
   assign bus.ocupado     = (estado != OCIOSO);

endmodule
